// File: rtl/uart_rx_core.sv
// uart_rx_core
// -----------------------------------------------------------------------------
// UART receiver (8N1, LSB first) feeding the CPU UART data/status registers.
// The asynchronous line is synchronised, oversampled, and each bit is decided
// by a 3-sample majority vote around the middle of the bit. A start bit that
// is not still low at mid-bit is treated as a glitch and ignored. A low stop
// bit reports a framing error and parks the receiver in BREAK until the line
// has been high for a full bit time.
//
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
// between the data bits and the stop bit (11-bit frame) and the parity_err
// output.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   UART_RX    serial line, idles high, asynchronous to clk
//   rd_ack     one-cycle pulse: CPU read of rx_data, clears rx_ready/overrun
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle strobe when rx_data is updated
//   rx_ready   sticky: unread byte present
//   frame_err  one-cycle strobe: stop bit sampled low
//   overrun    sticky: a byte arrived while rx_ready was still set
//   parity_err one-cycle strobe: parity mismatch (UART_RX_PARITY_EN only)
//   busy       receiver is not idle
//
// rd_ack/rx_valid handshake: rx_valid is a pure strobe with no back-pressure;
// rx_ready stays high from the rx_valid cycle until the clock edge that
// samples rd_ack=1. A byte completing on that same edge wins (rx_ready stays
// set, overrun is not set).
// -----------------------------------------------------------------------------
module uart_rx_core #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       UART_RX,
   input  logic       rd_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       busy
);

   localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t          state, state_n;
   logic            rx_meta, rxs, rxs_prev;
   logic [TW-1:0]   tick_cnt;
   logic [SW-1:0]   samp_cnt;
   logic [2:0]      bit_cnt;
   logic            smp_a, smp_b;
   logic [7:0]      shreg;
   logic            tick, decide, bit_end, maj, clr_cnt;
   logic            load_byte, frame_bad;
`ifdef UART_RX_PARITY_EN
   logic            par_bit, par_ok, par_bad;
`endif

   // Two-flop synchroniser plus one more flop for falling-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         rx_meta  <= UART_RX;
         rxs      <= rx_meta;
         rxs_prev <= rxs;
      end
   end

   // The tick that fires while samp_cnt == N brings the count to N+1, so the
   // ticks at samp_cnt 6/7/8 are sample points 7/8/9 (centred on mid-bit);
   // the one at 8 is also the bit decision, using rxs as the third sample.
   assign tick    = (tick_cnt == TW'(DIV - 1));
   assign decide  = tick && (samp_cnt == SW'(8));
   assign bit_end = tick && (samp_cnt == SW'(OVERSAMPLE - 1));
   assign maj     = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
   assign busy    = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
   assign par_ok  = (par_bit == ^shreg);
   assign par_bad = (state == S_STOP) && decide && !par_ok;
`endif

   // Counters restart on every state change so each phase is aligned to its
   // own entry; in BREAK a low line restarts the one-bit high window.
   assign clr_cnt = (state == S_IDLE) || (state_n != state) ||
                    ((state == S_BREAK) && !rxs);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      load_byte = 1'b0;
      frame_bad = 1'b0;
      case (state)
         S_IDLE: begin
            if (rxs_prev && !rxs) state_n = S_START;
         end
         S_START: begin
            if (decide && maj)  state_n = S_IDLE;
            else if (bit_end)   state_n = S_DATA;
         end
         S_DATA: begin
`ifdef UART_RX_PARITY_EN
            if (bit_end && (bit_cnt == 3'd7)) state_n = S_PARITY;
`else
            if (bit_end && (bit_cnt == 3'd7)) state_n = S_STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (bit_end) state_n = S_STOP;
         end
`endif
         S_STOP: begin
            // Leave at mid stop bit so a back-to-back start edge is caught.
            if (decide) begin
               if (maj) begin
                  state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  load_byte = par_ok;
`else
                  load_byte = 1'b1;
`endif
               end else begin
                  state_n   = S_BREAK;
                  frame_bad = 1'b1;
               end
            end
         end
         S_BREAK: begin
            if (rxs && bit_end) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
         samp_cnt <= '0;
         bit_cnt  <= 3'd0;
      end else begin
         if (clr_cnt) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
         end else if (tick) begin
            tick_cnt <= '0;
            samp_cnt <= (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + SW'(1);
         end else begin
            tick_cnt <= tick_cnt + TW'(1);
         end
         if (state == S_IDLE)                   bit_cnt <= 3'd0;
         else if ((state == S_DATA) && bit_end) bit_cnt <= bit_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         smp_a <= 1'b1;
         smp_b <= 1'b1;
         shreg <= 8'h00;
`ifdef UART_RX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         if (tick && (samp_cnt == SW'(6))) smp_a <= rxs;
         if (tick && (samp_cnt == SW'(7))) smp_b <= rxs;
         if ((state == S_DATA) && decide)  shreg <= {maj, shreg[7:1]};
`ifdef UART_RX_PARITY_EN
         if ((state == S_PARITY) && decide) par_bit <= maj;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         rx_ready  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         rx_valid  <= load_byte;
         frame_err <= frame_bad;
`ifdef UART_RX_PARITY_EN
         parity_err <= par_bad;
`endif
         if (load_byte) begin
            rx_data  <= shreg;
            rx_ready <= 1'b1;
            if (rx_ready && !rd_ack) overrun <= 1'b1;
         end else if (rd_ack) begin
            rx_ready <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
// Bench for uart_rx_core with a fast bit clock (DIV = 10, 160 clk per bit).
// Frames are driven on clock negedges; outputs are sampled on negedges.
module tb_uart_rx_core;

   localparam int CLK_FREQ    = 1600000;
   localparam int BAUD        = 10000;
   localparam int OVERSAMPLE  = 16;
   localparam int DIV         = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int BIT_CLK     = DIV * OVERSAMPLE;
   // Rising edge (counted from the first edge after the start fall) on which
   // the stop-bit decision is registered: 2 synchroniser edges, 9 bit times,
   // then 9 ticks into the stop bit.
   localparam int DECIDE_EDGE = 2 + 9 * BIT_CLK + 9 * DIV;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       UART_RX = 1'b1;
   logic       rd_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready, frame_err, overrun, busy;

   always #5 clk = ~clk;

   uart_rx_core #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .OVERSAMPLE(OVERSAMPLE)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .UART_RX  (UART_RX),
      .rd_ack   (rd_ack),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int checks = 0;
   int passes = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (frame_err) ferr_cnt++;
      if (rx_valid) begin
         valid_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_valid: got rx_data %0h, expected no byte", rx_data);
         end else begin
            check("rx_data_at_valid", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Leaves the line at the stop-bit level, one full bit after the stop start.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      @(negedge clk) UART_RX = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         UART_RX = d[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      UART_RX = stop_bit;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic ack_pulse();
      @(negedge clk) rd_ack = 1'b1;
      @(negedge clk) rd_ack = 1'b0;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [7:0] data;
      logic       ack_after;
      logic       exp_ready;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[5];
   logic [7:0] last_data;
   int v0, f0;

   initial begin
      vecs[0] = '{8'h54, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h0C, 1'b1, 1'b1, 1'b1};
      for (int i = 2; i < 5; i++)
         vecs[i] = '{8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0};

      // Reset state
      repeat (5) @(negedge clk);
      check("reset_rx_data", {24'h0, rx_data}, 32'h0);
      check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
      check("reset_rx_ready", {31'h0, rx_ready}, 32'h0);
      check("reset_frame_err", {31'h0, frame_err}, 32'h0);
      check("reset_overrun", {31'h0, overrun}, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);
      reset = 1'b1;
      repeat (20) @(negedge clk);

      // Table-driven frames
      for (int i = 0; i < 5; i++) begin
         v0 = valid_cnt;
         f0 = ferr_cnt;
         exp_q.push_back(vecs[i].data);
         send_frame(vecs[i].data, 1'b1);
         repeat (4) @(negedge clk);
         check("vec_rx_data", {24'h0, rx_data}, {24'h0, vecs[i].data});
         check("vec_valid_pulses", valid_cnt - v0, 32'd1);
         check("vec_rx_ready", {31'h0, rx_ready}, {31'h0, vecs[i].exp_ready});
         check("vec_overrun", {31'h0, overrun}, {31'h0, vecs[i].exp_ovr});
         check("vec_no_frame_err", ferr_cnt - f0, 32'd0);
         check("vec_queue_drained", exp_q.size(), 32'd0);
         if (vecs[i].ack_after) begin
            ack_pulse();
            check("ack_clears_ready", {31'h0, rx_ready}, 32'h0);
            check("ack_clears_overrun", {31'h0, overrun}, 32'h0);
         end
         last_data = vecs[i].data;
      end

      // Start-bit glitch (~1/50 bit low)
      v0 = valid_cnt;
      @(negedge clk) UART_RX = 1'b0;
      repeat (3) @(negedge clk);
      UART_RX = 1'b1;
      repeat (10) @(negedge clk);
      check("glitch_busy_rises", {31'h0, busy}, 32'h1);
      repeat (150) @(negedge clk);
      check("glitch_busy_drops", {31'h0, busy}, 32'h0);
      check("glitch_no_valid", valid_cnt - v0, 32'd0);

      // Framing error, line held low, then BREAK release
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'hA5, 1'b0);
      check("ferr_one_pulse", ferr_cnt - f0, 32'd1);
      repeat (2 * BIT_CLK) @(negedge clk);
      check("break_busy_low_line", {31'h0, busy}, 32'h1);
      check("ferr_no_retrigger", ferr_cnt - f0, 32'd1);
      check("ferr_rx_data_kept", {24'h0, rx_data}, {24'h0, last_data});
      check("ferr_rx_ready_kept", {31'h0, rx_ready}, 32'h0);
      check("ferr_no_valid", valid_cnt - v0, 32'd0);
      UART_RX = 1'b1;
      repeat (BIT_CLK / 2) @(negedge clk);
      check("break_busy_half_bit_high", {31'h0, busy}, 32'h1);
      repeat (BIT_CLK) @(negedge clk);
      check("break_released", {31'h0, busy}, 32'h0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      check("after_break_rx_data", {24'h0, rx_data}, 32'h3C);
      check("after_break_rx_ready", {31'h0, rx_ready}, 32'h1);

      // Reset in the middle of DATA of 8'hFF
      v0 = valid_cnt;
      @(negedge clk) UART_RX = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      UART_RX = 1'b1;
      repeat (3 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
      check("mid_frame_busy", {31'h0, busy}, 32'h1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_rx_data", {24'h0, rx_data}, 32'h0);
      check("async_rst_rx_ready", {31'h0, rx_ready}, 32'h0);
      check("async_rst_rx_valid", {31'h0, rx_valid}, 32'h0);
      check("async_rst_frame_err", {31'h0, frame_err}, 32'h0);
      check("async_rst_overrun", {31'h0, overrun}, 32'h0);
      check("async_rst_busy", {31'h0, busy}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (8 * BIT_CLK) @(negedge clk);
      check("post_rst_idle", {31'h0, busy}, 32'h0);
      check("post_rst_no_valid", valid_cnt - v0, 32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      repeat (4) @(negedge clk);
      check("post_rst_rx_data", {24'h0, rx_data}, 32'h81);
      check("post_rst_rx_ready", {31'h0, rx_ready}, 32'h1);

      // rd_ack on the same edge the next byte completes (0x81 still unread)
      exp_q.push_back(8'h5A);
      fork
         send_frame(8'h5A, 1'b1);
         begin
            @(negedge clk);
            repeat (DECIDE_EDGE) @(posedge clk);
            @(negedge clk) rd_ack = 1'b1;
            @(negedge clk) rd_ack = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      check("coinc_rx_data", {24'h0, rx_data}, 32'h5A);
      check("coinc_rx_ready", {31'h0, rx_ready}, 32'h1);
      check("coinc_overrun", {31'h0, overrun}, 32'h0);

      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
